// File: rtl/tmds_encoder_rgb.sv
// tmds_encoder_rgb: three-channel DVI 1.0 TMDS encoder, 2-stage pipeline.
// Ports: I_pxl_clk clock, I_rst sync active-high reset, I_de/I_hs/I_vs
//   timing, I_data_{r,g,b} 8-bit pixels, O_tmds_{r,g,b} 10-bit symbols
//   (bit 0 transmitted first). Blue carries hs/vs as c0/c1.
module tmds_encoder_rgb #(
    parameter int SYNC_INV = 0
) (
    input  logic       I_pxl_clk,
    input  logic       I_rst,
    input  logic       I_de,
    input  logic       I_hs,
    input  logic       I_vs,
    input  logic [7:0] I_data_r,
    input  logic [7:0] I_data_g,
    input  logic [7:0] I_data_b,
    output logic [9:0] O_tmds_r,
    output logic [9:0] O_tmds_g,
    output logic [9:0] O_tmds_b
);

    localparam logic INV = (SYNC_INV != 0);

    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;

    // Transition-minimising stage: choose XOR or XNOR chain so that
    // the 8 data bits carry as few transitions as possible.
    function automatic logic [8:0] qm_of(input logic [7:0] d);
        logic [3:0] n1;
        logic       xn;
        logic [8:0] q;
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + {3'b000, d[i]};
        end
        xn = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~xn;
        return q;
    endfunction

    logic hs_p;
    logic vs_p;
    assign hs_p = I_hs ^ INV;
    assign vs_p = I_vs ^ INV;

    // Stage 1 timing: reset value (de=0, c=00) makes the first symbol
    // after release a blank-00 control token.
    logic de_q;
    logic c0_q;
    logic c1_q;

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            de_q <= 1'b0;
            c0_q <= 1'b0;
            c1_q <= 1'b0;
        end else begin
            de_q <= I_de;
            c0_q <= hs_p;
            c1_q <= vs_p;
        end
    end

    logic [2:0][7:0] din;
    assign din = {I_data_r, I_data_g, I_data_b};

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [8:0] qm_q;
        logic [4:0] cnt;
        logic [9:0] sym_q;
        logic [3:0] n1q;
        logic [4:0] diff;
        logic [4:0] cnt_nx;
        logic [9:0] sym_nx;
        logic [1:0] ctl;
        logic       case_a;
        logic       case_b;

        assign ctl = (ch == 0) ? {c1_q, c0_q} : 2'b00;

        always_ff @(posedge I_pxl_clk) begin
            if (I_rst) begin
                qm_q <= 9'd0;
            end else begin
                qm_q <= qm_of(din[ch]);
            end
        end

        // diff = N1q - N0q = 2*N1q - 8, 5-bit two's complement.
        always_comb begin
            n1q = 4'd0;
            for (int i = 0; i < 8; i++) begin
                n1q = n1q + {3'b000, qm_q[i]};
            end
            diff = {n1q, 1'b0} - 5'd8;
            case_a = (cnt == 5'd0) || (diff == 5'd0);
            case_b = (!cnt[4] && (cnt != 5'd0) &&
                      !diff[4] && (diff != 5'd0)) ||
                     (cnt[4] && diff[4]);
        end

        always_comb begin
            sym_nx = CTL_00;
            cnt_nx = 5'd0;
            if (de_q) begin
                unique case (1'b1)
                    case_a: begin
                        sym_nx = {~qm_q[8], qm_q[8],
                                  qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                        cnt_nx = qm_q[8] ? cnt + diff : cnt - diff;
                    end
                    case_b: begin
                        sym_nx = {1'b1, qm_q[8], ~qm_q[7:0]};
                        cnt_nx = cnt + {3'b000, qm_q[8], 1'b0} - diff;
                    end
                    default: begin
                        sym_nx = {1'b0, qm_q[8], qm_q[7:0]};
                        cnt_nx = cnt + diff - {3'b000, ~qm_q[8], 1'b0};
                    end
                endcase
            end else begin
                // Blanking restarts disparity from zero.
                unique case (ctl)
                    2'b00:   sym_nx = CTL_00;
                    2'b01:   sym_nx = CTL_01;
                    2'b10:   sym_nx = CTL_10;
                    default: sym_nx = CTL_11;
                endcase
                cnt_nx = 5'd0;
            end
        end

        always_ff @(posedge I_pxl_clk) begin
            if (I_rst) begin
                cnt   <= 5'd0;
                sym_q <= 10'd0;
            end else begin
                cnt   <= cnt_nx;
                sym_q <= sym_nx;
            end
        end
    end

    assign O_tmds_b = g_ch[0].sym_q;
    assign O_tmds_g = g_ch[1].sym_q;
    assign O_tmds_r = g_ch[2].sym_q;

endmodule

// File: tb/tb_tmds_encoder_rgb.sv
// tb_tmds_encoder_rgb: vectors, corner sequences and a random run
// against a transaction-level DVI encoder model (SYNC_INV 0 and 1).
module tb_tmds_encoder_rgb;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       de = 1'b0;
    logic       hs = 1'b0;
    logic       vs = 1'b0;
    logic [7:0] dr = 8'd0;
    logic [7:0] dg = 8'd0;
    logic [7:0] db = 8'd0;
    logic [9:0] o_r, o_g, o_b;
    logic [9:0] i_r, i_g, i_b;

    int n_pass = 0;
    int n_tot = 0;

    always #5 clk = ~clk;

    tmds_encoder_rgb #(.SYNC_INV(0)) dut (
        .I_pxl_clk(clk), .I_rst(rst), .I_de(de), .I_hs(hs), .I_vs(vs),
        .I_data_r(dr), .I_data_g(dg), .I_data_b(db),
        .O_tmds_r(o_r), .O_tmds_g(o_g), .O_tmds_b(o_b)
    );

    tmds_encoder_rgb #(.SYNC_INV(1)) dut_inv (
        .I_pxl_clk(clk), .I_rst(rst), .I_de(de), .I_hs(hs), .I_vs(vs),
        .I_data_r(dr), .I_data_g(dg), .I_data_b(db),
        .O_tmds_r(i_r), .O_tmds_g(i_g), .O_tmds_b(i_b)
    );

    task automatic chk(input string nm, input logic [29:0] got,
                       input logic [29:0] want);
        n_tot++;
        if (got === want) n_pass++;
        else $display("FAIL %s at %0t: got %b want %b", nm, $time, got, want);
    endtask

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return C00;
            2'b01:   return C01;
            2'b10:   return C10;
            default: return C11;
        endcase
    endfunction

    // DVI 1.0 encoding of one byte given running disparity (plain ints).
    function automatic logic [9:0] tmds_enc(input logic [7:0] d,
                                            input int cin, output int cout);
        int n1, n1q, n0q;
        bit xn;
        logic [8:0] qm;
        logic [9:0] s;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (cin == 0 || n1q == n0q) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cout = cin + (qm[8] ? (n1q - n0q) : (n0q - n1q));
        end else if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + (qm[8] ? 2 : 0) + (n0q - n1q);
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            cout = cin + (n1q - n0q) - (qm[8] ? 0 : 2);
        end
        return s;
    endfunction

    function automatic logic [7:0] tmds_dec(input logic [9:0] s);
        logic [7:0] q, d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++)
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    // Model: output after edge e is a function of the inputs seen at
    // edge e-1, unless reset is seen at edge e.
    logic [9:0] exp_sym [2][3];
    int         mcnt [2][3];
    logic       exp_dv = 1'b0;
    logic [7:0] exp_d [3];
    bit         p_rst = 1'b1;
    bit         p_de = 1'b0;
    bit         p_hs = 1'b0;
    bit         p_vs = 1'b0;
    logic [7:0] p_d [3];

    task automatic model_step();
        logic [7:0] cur [3];
        logic [1:0] cb;
        int nc;
        cur[0] = db; cur[1] = dg; cur[2] = dr;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
                if (rst) begin
                    exp_sym[k][c] = 10'd0;
                    mcnt[k][c] = 0;
                end else if (p_rst || !p_de) begin
                    if (p_rst || c != 0) cb = 2'b00;
                    else if (k == 1) cb = {~p_vs, ~p_hs};
                    else cb = {p_vs, p_hs};
                    exp_sym[k][c] = ctl_sym(cb);
                    mcnt[k][c] = 0;
                end else begin
                    exp_sym[k][c] = tmds_enc(p_d[c], mcnt[k][c], nc);
                    mcnt[k][c] = nc;
                end
            end
        end
        exp_dv = !rst && !p_rst && p_de;
        for (int c = 0; c < 3; c++) exp_d[c] = p_d[c];
        p_rst = rst; p_de = de; p_hs = hs; p_vs = vs;
        for (int c = 0; c < 3; c++) p_d[c] = cur[c];
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("model_sym", {o_r, o_g, o_b},
            {exp_sym[0][2], exp_sym[0][1], exp_sym[0][0]});
        chk("model_sym_inv", {i_r, i_g, i_b},
            {exp_sym[1][2], exp_sym[1][1], exp_sym[1][0]});
        if (exp_dv)
            chk("decode", {6'd0, tmds_dec(o_r), tmds_dec(o_g), tmds_dec(o_b)},
                {6'd0, exp_d[2], exp_d[1], exp_d[0]});
    end

    task automatic step(input bit r_, input bit de_, input bit hs_,
                        input bit vs_, input logic [7:0] xr,
                        input logic [7:0] xg, input logic [7:0] xb);
        @(negedge clk);
        rst = r_; de = de_; hs = hs_; vs = vs_;
        dr = xr; dg = xg; db = xb;
    endtask

    function automatic logic [7:0] rbyte();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    typedef struct {
        bit de, hs, vs;
        logic [7:0] r, g, b;
        logic [9:0] er, eg, eb, ebi;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{0, 0, 0, 8'h12, 8'h34, 8'h56, C00, C00, C00, C11};
        tbl[1] = '{0, 1, 0, 8'h00, 8'h00, 8'h00, C00, C00, C01, C10};
        tbl[2] = '{0, 0, 1, 8'hFF, 8'hFF, 8'hFF, C00, C00, C10, C01};
        tbl[3] = '{0, 1, 1, 8'hA5, 8'h5A, 8'h3C, C00, C00, C11, C00};
        tbl[4] = '{1, 0, 0, 8'h00, 8'hFF, 8'h01,
                   10'b0100000000, 10'b1000000000,
                   10'b0111111111, 10'b0111111111};
        tbl[5] = '{1, 0, 0, 8'h55, 8'hAA, 8'h10,
                   10'b0100110011, 10'b1000110011,
                   10'b0111110000, 10'b0111110000};
        tbl[6] = '{1, 1, 1, 8'hFF, 8'h00, 8'h55,
                   10'b1000000000, 10'b0100000000,
                   10'b0100110011, 10'b0100110011};

        rst = 1'b1; de = 1'b1; hs = 1'b1; vs = 1'b1;
        dr = 8'h5A; dg = 8'hC3; db = 8'h0F;

        // Reset holds everything at zero whatever the inputs do.
        for (int i = 0; i < 3; i++) begin
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rbyte(), rbyte(), rbyte());
            chk("rst_zero", {o_r, o_g, o_b}, 30'd0);
            chk("rst_zero_inv", {i_r, i_g, i_b}, 30'd0);
        end
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("rst_first", {o_r, o_g, o_b}, {C00, C00, C00});
        chk("rst_first_inv", {i_r, i_g, i_b}, {C00, C00, C00});
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("rst_second_inv", {i_r, i_g, i_b}, {C00, C00, C11});

        // Single-cycle vectors, each from a blank so cnt starts at 0.
        for (int v = 0; v < 7; v++) begin
            step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
            step(0, tbl[v].de, tbl[v].hs, tbl[v].vs,
                 tbl[v].r, tbl[v].g, tbl[v].b);
            step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
            step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
            chk("tbl_sym", {o_r, o_g, o_b}, {tbl[v].er, tbl[v].eg, tbl[v].eb});
            chk("tbl_inv", {i_r, i_g, i_b}, {tbl[v].er, tbl[v].eg, tbl[v].ebi});
        end

        // Disparity walk on 0x00.
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("zero_1", {20'd0, o_b}, {20'd0, 10'b0100000000});
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("zero_2", {20'd0, o_b}, {20'd0, 10'b1111111111});
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("zero_3", {20'd0, o_b}, {20'd0, 10'b0100000000});

        // Saturated green.
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step(0, 1, 0, 0, 8'h00, 8'hFF, 8'h00);
        step(0, 1, 0, 0, 8'h00, 8'hFF, 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("ff_1", {20'd0, o_g}, {20'd0, 10'b1000000000});
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("ff_2", {20'd0, o_g}, {20'd0, 10'b0011111111});

        // Line of 0xFF ends with cnt < 0; one blank must clear it.
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("pulse_early", {o_r, o_g, o_b}, {C00, C00, C00});
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("pulse_sym", {o_r, o_g, o_b},
            {10'b0100000000, 10'b0100000000, 10'b0100000000});
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("pulse_after", {o_r, o_g, o_b}, {C00, C00, C00});

        // Reset mid-line discards in-flight pixels and clears cnt.
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'hAA, 8'h0F, 8'hFF);
        step(1, 1, 0, 0, 8'hAA, 8'h0F, 8'hFF);
        step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("mid_rst_zero", {o_r, o_g, o_b}, 30'd0);
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("mid_rst_ctl", {o_r, o_g, o_b}, {C00, C00, C00});
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("mid_rst_data", {o_r, o_g, o_b},
            {10'b0100000000, 10'b0100000000, 10'b0100000000});

        // Random lines and blanks of varied length.
        begin
            int cyc = 0;
            while (cyc < 12000) begin
                int act = $urandom_range(1, 150);
                int blk = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 40);
                for (int a = 0; a < act; a++)
                    step(($urandom_range(0, 999) == 0), 1,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         rbyte(), rbyte(), rbyte());
                for (int b = 0; b < blk; b++)
                    step(0, 0, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), rbyte(), rbyte(), rbyte());
                cyc += act + blk;
            end
        end

        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
